// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud-select codes and the
// 16x oversampling divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [2:0] BAUD_4800   = 3'd0;
  localparam logic [2:0] BAUD_9600   = 3'd1;
  localparam logic [2:0] BAUD_115200 = 3'd2;
  localparam logic [2:0] BAUD_19200  = 3'd3;

  localparam int OS_RATE    = 16;
  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 8;

  // Codes 4..7 fall back to 115200.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [2:0] baud_set);
    int unsigned baud;
    case (baud_set)
      BAUD_4800:  baud = 4800;
      BAUD_9600:  baud = 9600;
      BAUD_19200: baud = 19200;
      default:    baud = 115200;
    endcase
    return clk_freq / (baud * OS_RATE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divisor counter producing one oversampling tick every div cycles.
module uart_baud_tick #(
  parameter int CNT_W = 10
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_reg;

  // >= keeps the counter bounded even if div shrinks while counting.
  assign tick = (cnt_reg >= (div - CNT_W'(1)));

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver with majority-vote sampling, optional parity,
// false-start rejection and parity/framing error flags.
import uart_pkg::*;

module uart_rx_os16 #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [2:0]        Baud_set,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] Data,
  output logic              rx_done,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(baud_div(CLK_FREQ, BAUD_4800) + 1);
  localparam logic [CNT_W-1:0] DIV_4800   = CNT_W'(baud_div(CLK_FREQ, BAUD_4800));
  localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(baud_div(CLK_FREQ, BAUD_9600));
  localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(baud_div(CLK_FREQ, BAUD_19200));
  localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(baud_div(CLK_FREQ, BAUD_115200));
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_W - 1);
  localparam logic             ODD        = (PARITY_ODD != 0);

  logic              sync1_reg, sync2_reg, edge_reg;
  logic [CNT_W-1:0]  div_reg, div_next;
  rx_state_t         state_reg;
  logic [3:0]        tick_idx_reg;
  logic [2:0]        ones_reg, ones_next;
  logic [2:0]        bit_cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              par_mis_reg;
  logic [DATA_W-1:0] data_reg;
  logic              rx_done_reg, parity_err_reg, frame_err_reg;
  logic              falling, tick, clr, sample_win, bit_val;

  assign Data       = data_reg;
  assign rx_done    = rx_done_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

  assign falling = edge_reg & ~sync2_reg;
  assign clr     = (state_reg == IDLE) && falling;

  always_comb begin
    div_next = DIV_115200;
    case (Baud_set)
      BAUD_4800:  div_next = DIV_4800;
      BAUD_9600:  div_next = DIV_9600;
      BAUD_19200: div_next = DIV_19200;
      default:    div_next = DIV_115200;
    endcase
  end

  // Include the current sample so the stop bit can be judged on tick 10 itself.
  assign sample_win = (tick_idx_reg >= 4'd6) && (tick_idx_reg <= 4'd10);
  assign ones_next  = sample_win ? (ones_reg + {2'b00, sync2_reg}) : ones_reg;
  assign bit_val    = (ones_next >= 3'd3);

  uart_baud_tick #(
    .CNT_W (CNT_W)
  ) u_tick (
    .sysclk (sysclk),
    .rst    (rst),
    .clr    (clr),
    .div    (div_reg),
    .tick   (tick)
  );

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      edge_reg  <= 1'b1;
    end else begin
      sync1_reg <= uart_rx;
      sync2_reg <= sync1_reg;
      edge_reg  <= sync2_reg;
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      div_reg        <= DIV_115200;
      tick_idx_reg   <= '0;
      ones_reg       <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_mis_reg    <= 1'b0;
      data_reg       <= '0;
      rx_done_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        div_reg      <= div_next;
        tick_idx_reg <= '0;
        ones_reg     <= '0;
        bit_cnt_reg  <= '0;
        par_mis_reg  <= 1'b0;
        if (falling) state_reg <= START;
      end else if (tick) begin
        tick_idx_reg <= tick_idx_reg + 4'd1;
        ones_reg     <= (tick_idx_reg == 4'd15) ? 3'd0 : ones_next;
        case (state_reg)
          START: begin
            if (tick_idx_reg == 4'd15) state_reg <= bit_val ? IDLE : DATA;
          end
          DATA: begin
            if (tick_idx_reg == 4'd15) begin
              shift_reg   <= {bit_val, shift_reg[DATA_W-1:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == LAST_BIT)
                state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (tick_idx_reg == 4'd15) begin
              par_mis_reg <= bit_val ^ (^shift_reg) ^ ODD;
              state_reg   <= STOP;
            end
          end
          STOP: begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            if (tick_idx_reg == 4'd10) begin
              data_reg       <= shift_reg;
              frame_err_reg  <= ~bit_val;
              parity_err_reg <= (PARITY_EN != 0) ? par_mis_reg : 1'b0;
              rx_done_reg    <= 1'b1;
              state_reg      <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench: an 8N1 and an 8E1 receiver at 115200 baud, 50 MHz.
module tb_uart_rx_os16;

  localparam int DIV = 27;
  localparam int BIT = 16 * DIV;

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned due;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] baud_set = 3'd2;
  logic       pin_a = 1'b1, pin_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       done_a, done_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       prev_done_a = 1'b0, prev_done_b = 1'b0;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #10 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  uart_rx_os16 #(.CLK_FREQ(50_000_000), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .sysclk(sysclk), .rst(rst), .Baud_set(baud_set), .uart_rx(pin_a),
    .Data(data_a), .rx_done(done_a), .parity_err(perr_a), .frame_err(ferr_a)
  );

  uart_rx_os16 #(.CLK_FREQ(50_000_000), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .sysclk(sysclk), .rst(rst), .Baud_set(baud_set), .uart_rx(pin_b),
    .Data(data_b), .rx_done(done_b), .parity_err(perr_b), .frame_err(ferr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lat_dev(input int unsigned now, input int unsigned due);
    int d;
    d = int'(now) - int'(due);
    return (d >= -1 && d <= 1) ? 32'd0 : 32'(d);
  endfunction

  // Monitor: pops one expectation per rx_done and flags overdue ones.
  always @(negedge sysclk) begin
    exp_t e;
    if (done_a) begin
      check("a_pulse_width", {31'd0, prev_done_a}, 32'd0);
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        $display("rx a: data=%02h perr=%0d ferr=%0d at cycle %0d (due %0d)",
                 data_a, perr_a, ferr_a, cyc, e.due);
        check("a_data", {24'd0, data_a}, {24'd0, e.data});
        check("a_parity_err", {31'd0, perr_a}, {31'd0, e.perr});
        check("a_frame_err", {31'd0, ferr_a}, {31'd0, e.ferr});
        check("a_latency_dev", lat_dev(cyc, e.due), 32'd0);
      end
    end else if (q_a.size() > 0 && cyc > q_a[0].due + 2) begin
      e = q_a.pop_front();
      check("a_done_missing", 32'd0, 32'd1);
    end
    if (done_b) begin
      check("b_pulse_width", {31'd0, prev_done_b}, 32'd0);
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        $display("rx b: data=%02h perr=%0d ferr=%0d at cycle %0d (due %0d)",
                 data_b, perr_b, ferr_b, cyc, e.due);
        check("b_data", {24'd0, data_b}, {24'd0, e.data});
        check("b_parity_err", {31'd0, perr_b}, {31'd0, e.perr});
        check("b_frame_err", {31'd0, ferr_b}, {31'd0, e.ferr});
        check("b_latency_dev", lat_dev(cyc, e.due), 32'd0);
      end
    end else if (q_b.size() > 0 && cyc > q_b[0].due + 2) begin
      e = q_b.pop_front();
      check("b_done_missing", 32'd0, 32'd1);
    end
    prev_done_a = done_a;
    prev_done_b = done_b;
  end

  task automatic drive(input int ch, input logic v);
    if (ch == 0) pin_a = v;
    else         pin_b = v;
  endtask

  // Sends start, 8 data bits LSB first, optional parity, one stop bit, then idle.
  task automatic send_frame(input int ch, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input logic stop_bit,
                            input bit expect_done, input logic exp_perr,
                            input logic exp_ferr, input int idle_bits);
    exp_t e;
    @(negedge sysclk);
    drive(ch, 1'b0);
    if (expect_done) begin
      e.data = d;
      e.perr = exp_perr;
      e.ferr = exp_ferr;
      e.due  = cyc + 3 + DIV * (par_en ? 171 : 155);
      if (ch == 0) q_a.push_back(e);
      else         q_b.push_back(e);
    end
    repeat (BIT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      drive(ch, d[i]);
      repeat (BIT) @(negedge sysclk);
    end
    if (par_en) begin
      drive(ch, par_bit);
      repeat (BIT) @(negedge sysclk);
    end
    drive(ch, stop_bit);
    repeat (BIT) @(negedge sysclk);
    drive(ch, 1'b1);
    repeat (idle_bits * BIT) @(negedge sysclk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_a"}, {24'd0, data_a}, 32'd0);
    check({tag, "_done_a"}, {31'd0, done_a}, 32'd0);
    check({tag, "_perr_a"}, {31'd0, perr_a}, 32'd0);
    check({tag, "_ferr_a"}, {31'd0, ferr_a}, 32'd0);
    check({tag, "_data_b"}, {24'd0, data_b}, 32'd0);
    check({tag, "_perr_b"}, {31'd0, perr_b}, 32'd0);
    check({tag, "_ferr_b"}, {31'd0, ferr_b}, 32'd0);
  endtask

  initial begin
    repeat (5) @(negedge sysclk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (10) @(negedge sysclk);

    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1);
    // 8E1: 0x3C has four ones, so the correct even parity bit is 0.
    send_frame(1, 8'h3C, 1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1);
    send_frame(1, 8'h3C, 1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1);
    send_frame(1, 8'h3C, 1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1);

    send_frame(0, 8'h55, 0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1);
    send_frame(0, 8'h0F, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1);

    // 4-tick low glitch must be rejected as a false start.
    @(negedge sysclk);
    pin_a = 1'b0;
    repeat (108) @(negedge sysclk);
    pin_a = 1'b1;
    repeat (1000) @(negedge sysclk);
    send_frame(0, 8'h6E, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1);

    // Reset in the middle of the data bits of 0xFF.
    fork
      send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1);
      begin
        repeat (4 * BIT) @(negedge sysclk);
        rst = 1'b0;
        repeat (3) @(negedge sysclk);
        check_outputs_zero("midreset");
        rst = 1'b1;
      end
    join
    send_frame(0, 8'h81, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1);

    // Back-to-back frames; the baud select glitch during the first is ignored.
    fork
      begin
        send_frame(0, 8'h12, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 0);
        send_frame(0, 8'h34, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1);
      end
      begin
        repeat (2000) @(negedge sysclk);
        baud_set = 3'd0;
        repeat (1000) @(negedge sysclk);
        baud_set = 3'd2;
      end
    join

    repeat (500) @(negedge sysclk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
